// File: rtl/ram_stream_loader_if.sv
// Byte-stream and RAM slave-port bundle for ram_stream_loader.
// master = the loader, slave = the byte source plus the RAM.
interface ram_stream_loader_if #(
  parameter int ADDR_W = 13
);
  logic [7:0]        st_data;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic              ram_clken;
  logic [31:0]       ram_readdata;

  modport master (
    input  st_data, st_valid, ram_readdata,
    output st_ready, ram_address, ram_byteenable, ram_chipselect,
           ram_write, ram_writedata, ram_clken
  );

  modport slave (
    output st_data, st_valid, ram_readdata,
    input  st_ready, ram_address, ram_byteenable, ram_chipselect,
           ram_write, ram_writedata, ram_clken
  );
endinterface

// File: rtl/ram_stream_loader.sv
// Packs a byte stream little-endian into 32-bit words, writes them to consecutive
// RAM words, then reads the region back and compares against the write checksum.
module ram_stream_loader #(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 5120,
  parameter int BASE_WORD = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [15:0]         length_bytes,
  ram_stream_loader_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [31:0]         checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WRITE,
    S_VERIFY,
    S_FINISH
  } state_e;

  localparam int                ROOM      = DEPTH - BASE_WORD;
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);

  state_e r_state;

  // Transfer bookkeeping
  logic [15:0] r_length;
  logic [15:0] r_byte_cnt;
  logic [15:0] r_word_cnt;
  logic [15:0] r_rd_idx;
  logic [15:0] r_cap_idx;
  logic [31:0] r_pack;
  logic [3:0]  r_lane_mask;
  logic [3:0]  r_tail_mask;
  logic        r_verified;
  logic        r_cap_pend;
  logic [31:0] r_vsum;

  // Registered outputs
  logic              r_st_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic              r_cs;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic              r_clken;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [31:0]       r_checksum;

  logic [16:0] w_words_req;
  logic        w_accept;
  logic [1:0]  w_lane;
  logic [31:0] w_pack_next;
  logic [3:0]  w_mask_next;
  logic        w_last_byte;
  logic        w_rd_last;
  logic        w_cap_last;
  logic [31:0] w_tail_bits;
  logic [31:0] w_cap_word;

  assign w_words_req = ({1'b0, length_bytes} + 17'd3) >> 2;

  // r_st_ready is only ever high in FILL, so this is the whole acceptance rule.
  assign w_accept    = bus.st_valid & r_st_ready;
  assign w_lane      = r_byte_cnt[1:0];
  assign w_pack_next = r_pack | ({24'd0, bus.st_data} << {w_lane, 3'b000});
  assign w_mask_next = r_lane_mask | (4'b0001 << w_lane);
  assign w_last_byte = (r_byte_cnt == r_length - 16'd1);

  assign w_rd_last   = (r_rd_idx  == r_word_cnt - 16'd1);
  assign w_cap_last  = (r_cap_idx == r_word_cnt - 16'd1);
  assign w_tail_bits = {{8{r_tail_mask[3]}}, {8{r_tail_mask[2]}},
                        {8{r_tail_mask[1]}}, {8{r_tail_mask[0]}}};
  // Unwritten upper lanes of the tail word hold stale RAM data; mask them out.
  assign w_cap_word  = w_cap_last ? (bus.ram_readdata & w_tail_bits) : bus.ram_readdata;

  // NOTE: every register here is assigned with <= so all branches read pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_length    <= '0;
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_rd_idx    <= '0;
      r_cap_idx   <= '0;
      r_pack      <= '0;
      r_lane_mask <= '0;
      r_tail_mask <= '0;
      r_verified  <= 1'b0;
      r_cap_pend  <= 1'b0;
      r_vsum      <= '0;
      r_st_ready  <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_clken     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_checksum  <= '0;
    end else begin
      r_clken <= 1'b1;
      // NOTE: done defaults low every cycle so it can only ever be a single-cycle pulse.
      r_done  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_length    <= length_bytes;
            r_byte_cnt  <= '0;
            r_word_cnt  <= '0;
            r_pack      <= '0;
            r_lane_mask <= '0;
            r_checksum  <= '0;
            r_vsum      <= '0;
            r_error     <= 1'b0;
            r_verified  <= 1'b0;
            r_busy      <= 1'b1;
            if (length_bytes == 16'd0) begin
              r_state <= S_FINISH;
            end else if (int'(w_words_req) > ROOM) begin
              r_error <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_st_ready <= 1'b1;
              r_state    <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (w_accept) begin
            r_pack      <= w_pack_next;
            r_lane_mask <= w_mask_next;
            r_byte_cnt  <= r_byte_cnt + 16'd1;
            if (w_lane == 2'd3 || w_last_byte) begin
              r_st_ready <= 1'b0;
              r_cs       <= 1'b1;
              r_we       <= 1'b1;
              r_addr     <= BASE_ADDR + r_word_cnt[ADDR_W-1:0];
              r_be       <= w_mask_next;
              r_wdata    <= w_pack_next;
              r_state    <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          r_checksum  <= r_checksum + r_wdata;
          r_tail_mask <= r_be;
          r_word_cnt  <= r_word_cnt + 16'd1;
          r_pack      <= '0;
          r_lane_mask <= '0;
          r_we        <= 1'b0;
          r_wdata     <= '0;
          if (r_byte_cnt != r_length) begin
            r_cs       <= 1'b0;
            r_be       <= '0;
            r_st_ready <= 1'b1;
            r_state    <= S_FILL;
          end else begin
            // First readback address goes out on the very next cycle.
            r_cs       <= 1'b1;
            r_be       <= 4'hF;
            r_addr     <= BASE_ADDR;
            r_rd_idx   <= '0;
            r_cap_idx  <= '0;
            r_cap_pend <= 1'b0;
            r_verified <= 1'b1;
            r_state    <= S_VERIFY;
          end
        end

        S_VERIFY: begin
          // Read data appears one cycle after its address, so capture trails issue.
          r_cap_pend <= r_cs;
          if (r_cs) begin
            if (w_rd_last) begin
              r_cs <= 1'b0;
              r_be <= '0;
            end else begin
              r_rd_idx <= r_rd_idx + 16'd1;
              r_addr   <= r_addr + ADDR_W'(1);
            end
          end
          if (r_cap_pend) begin
            r_vsum    <= r_vsum + w_cap_word;
            r_cap_idx <= r_cap_idx + 16'd1;
            if (w_cap_last) begin
              r_state <= S_FINISH;
            end
          end
        end

        S_FINISH: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_addr <= '0;
          if (r_verified) begin
            r_error <= (r_vsum != r_checksum);
          end
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.st_ready       = r_st_ready;
  assign bus.ram_address    = r_addr;
  assign bus.ram_byteenable = r_be;
  assign bus.ram_chipselect = r_cs;
  assign bus.ram_write      = r_we;
  assign bus.ram_writedata  = r_wdata;
  assign bus.ram_clken      = r_clken;

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign checksum = r_checksum;

endmodule
